// File: rtl/vehicle_direction_detector_pkg.sv
// Shared definitions for the gate-lane direction detector: state encoding, fault-clear
// length and the {beam_out, beam_in} sensor patterns.
package vehicle_direction_detector_pkg;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StEn1   = 3'd1,
      StEn2   = 3'd2,
      StEn3   = 3'd3,
      StEx1   = 3'd4,
      StEx2   = 3'd5,
      StEx3   = 3'd6,
      StFault = 3'd7
   } vdd_state_t;

   localparam int unsigned FAULT_CLEAR_CYCLES = 4;

   localparam logic [1:0] P_NONE = 2'b00;
   localparam logic [1:0] P_OUT  = 2'b10;
   localparam logic [1:0] P_IN   = 2'b01;
   localparam logic [1:0] P_BOTH = 2'b11;

endpackage

// File: rtl/vehicle_direction_detector_if.sv
// Sensor inputs, timebase and event outputs of the direction detector.
interface vehicle_direction_detector_if;

   logic tick;
   logic beam_out;
   logic beam_in;
   logic entry_pulse;
   logic exit_pulse;
   logic busy;
   logic fault;

   modport master (
      output tick, beam_out, beam_in,
      input  entry_pulse, exit_pulse, busy, fault
   );

   modport slave (
      input  tick, beam_out, beam_in,
      output entry_pulse, exit_pulse, busy, fault
   );

endinterface

// File: rtl/vehicle_direction_detector_passage_timer.sv
// 16-bit tick counter with synchronous clear; o_expire flags an enabled tick that lands
// on the last count before TERMINAL.
module passage_timer #(
   parameter int unsigned TERMINAL = 2000
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expire
);

   localparam logic [15:0] LastCount = 16'(TERMINAL - 1);

   logic [15:0] r_count;

   always_ff @(posedge i_clk) begin
      if (i_reset || i_clear) begin
         r_count <= 16'd0;
      end else if (i_enable) begin
         r_count <= r_count + 16'd1;
      end
   end

   assign o_expire = i_enable && (r_count == LastCount);

endmodule

// File: rtl/vehicle_direction_detector.sv
// Decodes the break/clear order of the outer and inner gate beams into single-cycle entry
// and exit events, rejecting aborted passages, illegal patterns and stalled passages.
module vehicle_direction_detector
   import vehicle_direction_detector_pkg::*;
#(
   parameter int unsigned TIMEOUT_TICKS = 2000
) (
   input  logic                          i_clk,
   input  logic                          i_reset,
   vehicle_direction_detector_if.slave   io_vdd
);

   localparam logic [1:0] ZeroRunLast = 2'(FAULT_CLEAR_CYCLES - 1);

   vdd_state_t r_state;
   vdd_state_t w_state_d;
   logic [1:0] r_zero_run;
   logic [1:0] w_pat;
   logic       w_in_passage;
   logic       w_expire;
   logic       w_timeout;
   logic       w_tmr_clear;
   logic       w_entry_d;
   logic       w_exit_d;
   logic       r_entry;
   logic       r_exit;
   logic       r_busy;
   logic       r_fault;

   assign w_pat        = {io_vdd.beam_out, io_vdd.beam_in};
   assign w_in_passage = (r_state != StIdle) && (r_state != StFault);
   assign w_timeout    = w_in_passage && w_expire;
   assign w_tmr_clear  = (w_state_d != r_state) || !w_in_passage;

   passage_timer #(
      .TERMINAL (TIMEOUT_TICKS)
   ) u_passage_timer (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_clear  (w_tmr_clear),
      .i_enable (io_vdd.tick),
      .o_expire (w_expire)
   );

   always_comb begin
      w_state_d = r_state;
      w_entry_d = 1'b0;
      w_exit_d  = 1'b0;
      unique case (r_state)
         StIdle: begin
            case (w_pat)
               P_OUT:   w_state_d = StEn1;
               P_IN:    w_state_d = StEx1;
               P_BOTH:  w_state_d = StFault;
               default: ;
            endcase
         end
         StEn1: begin
            case (w_pat)
               P_BOTH:  w_state_d = StEn2;
               P_NONE:  w_state_d = StIdle;
               P_IN:    w_state_d = StFault;
               default: ;
            endcase
         end
         StEn2: begin
            case (w_pat)
               P_IN:    w_state_d = StEn3;
               P_OUT:   w_state_d = StEn1;
               P_NONE:  w_state_d = StFault;
               default: ;
            endcase
         end
         StEn3: begin
            case (w_pat)
               P_NONE: begin
                  w_state_d = StIdle;
                  w_entry_d = 1'b1;
               end
               P_BOTH:  w_state_d = StEn2;
               P_OUT:   w_state_d = StFault;
               default: ;
            endcase
         end
         StEx1: begin
            case (w_pat)
               P_BOTH:  w_state_d = StEx2;
               P_NONE:  w_state_d = StIdle;
               P_OUT:   w_state_d = StFault;
               default: ;
            endcase
         end
         StEx2: begin
            case (w_pat)
               P_OUT:   w_state_d = StEx3;
               P_IN:    w_state_d = StEx1;
               P_NONE:  w_state_d = StFault;
               default: ;
            endcase
         end
         StEx3: begin
            case (w_pat)
               P_NONE: begin
                  w_state_d = StIdle;
                  w_exit_d  = 1'b1;
               end
               P_BOTH:  w_state_d = StEx2;
               P_IN:    w_state_d = StFault;
               default: ;
            endcase
         end
         StFault: begin
            if (w_pat == P_NONE && r_zero_run == ZeroRunLast) begin
               w_state_d = StIdle;
            end
         end
         default: w_state_d = StFault;
      endcase
      // A stalled passage wins over whatever the beams decode to this cycle.
      if (w_timeout) begin
         w_state_d = StFault;
         w_entry_d = 1'b0;
         w_exit_d  = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= StIdle;
         r_zero_run <= 2'd0;
         r_entry    <= 1'b0;
         r_exit     <= 1'b0;
         r_busy     <= 1'b0;
         r_fault    <= 1'b0;
      end else begin
         r_state <= w_state_d;
         if (r_state == StFault && w_state_d == StFault && w_pat == P_NONE) begin
            r_zero_run <= r_zero_run + 2'd1;
         end else begin
            r_zero_run <= 2'd0;
         end
         r_entry <= w_entry_d;
         r_exit  <= w_exit_d;
         r_busy  <= (w_state_d != StIdle) && (w_state_d != StFault);
         r_fault <= (w_state_d == StFault);
      end
   end

   assign io_vdd.entry_pulse = r_entry;
   assign io_vdd.exit_pulse  = r_exit;
   assign io_vdd.busy        = r_busy;
   assign io_vdd.fault       = r_fault;

endmodule

// File: tb/tb_vehicle_direction_detector.sv
// Directed passages plus a random beam walk, checked cycle by cycle against a model that
// tracks the vehicle's position along the lane.
module tb_vehicle_direction_detector;

   localparam int unsigned TIMEOUT = 5;

   logic clk = 1'b0;
   logic rst = 1'b0;

   vehicle_direction_detector_if vif ();

   vehicle_direction_detector #(
      .TIMEOUT_TICKS (TIMEOUT)
   ) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .io_vdd  (vif)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int n_entry_seen = 0;
   int n_exit_seen = 0;

   // Model: direction of travel (0 none, 1 entering, 2 exiting), position 1..3 along the
   // lane as seen from the first beam broken, fault flag, tick count and 00 run in fault.
   int m_dir = 0;
   int m_pos = 0;
   bit m_fault = 1'b0;
   int m_tcnt = 0;
   int m_zeros = 0;
   bit exp_entry = 1'b0;
   bit exp_exit = 1'b0;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_step(input bit b_out, input bit b_in, input bit tk, input bit r);
      int old_key;
      int new_key;
      int p;
      bit a;
      bit b;
      exp_entry = 1'b0;
      exp_exit  = 1'b0;
      if (r) begin
         m_dir = 0; m_pos = 0; m_fault = 1'b0; m_tcnt = 0; m_zeros = 0;
         return;
      end
      old_key = m_fault * 100 + m_dir * 10 + m_pos;
      if (m_fault) begin
         if (!b_out && !b_in) begin
            m_zeros++;
            if (m_zeros == 4) begin
               m_fault = 1'b0;
               m_zeros = 0;
            end
         end else begin
            m_zeros = 0;
         end
      end else if (m_dir == 0) begin
         if (b_out && b_in) begin
            m_fault = 1'b1; m_zeros = 0;
         end else if (b_out) begin
            m_dir = 1; m_pos = 1;
         end else if (b_in) begin
            m_dir = 2; m_pos = 1;
         end
      end else begin
         a = (m_dir == 1) ? b_out : b_in;
         b = (m_dir == 1) ? b_in : b_out;
         p = (a && !b) ? 1 : (a && b) ? 2 : (!a && b) ? 3 : 0;
         if (tk && m_tcnt == TIMEOUT - 1) begin
            m_fault = 1'b1; m_dir = 0; m_pos = 0; m_zeros = 0;
         end else if (p == m_pos) begin
            // vehicle still at same position
         end else if (p == 0 && m_pos == 3) begin
            if (m_dir == 1) exp_entry = 1'b1;
            else exp_exit = 1'b1;
            m_dir = 0; m_pos = 0;
         end else if (p - m_pos == 1 || m_pos - p == 1) begin
            m_pos = p;
            if (p == 0) m_dir = 0;
         end else begin
            m_fault = 1'b1; m_dir = 0; m_pos = 0; m_zeros = 0;
         end
      end
      new_key = m_fault * 100 + m_dir * 10 + m_pos;
      if (new_key != old_key || m_dir == 0 || m_fault) m_tcnt = 0;
      else if (tk) m_tcnt++;
   endtask

   // Drive one cycle, advance the model at the edge, check the registered outputs after it.
   task automatic cycle(input logic [1:0] pat, input bit tk, input bit r);
      vif.beam_out = pat[1];
      vif.beam_in  = pat[0];
      vif.tick     = tk;
      rst          = r;
      @(posedge clk);
      model_step(pat[1], pat[0], tk, r);
      #1;
      check_eq("entry_pulse", int'(vif.entry_pulse), int'(exp_entry));
      check_eq("exit_pulse", int'(vif.exit_pulse), int'(exp_exit));
      check_eq("busy", int'(vif.busy), int'(m_dir != 0 && !m_fault));
      check_eq("fault", int'(vif.fault), int'(m_fault));
      check_eq("pulse_excl", int'(vif.entry_pulse && vif.exit_pulse), 0);
      if (vif.entry_pulse) n_entry_seen++;
      if (vif.exit_pulse) n_exit_seen++;
   endtask

   task automatic hold(input logic [1:0] pat, input int n);
      for (int i = 0; i < n; i++) cycle(pat, 1'b0, 1'b0);
   endtask

   task automatic clear_counts();
      n_entry_seen = 0;
      n_exit_seen = 0;
   endtask

   initial begin
      logic [1:0] seq [4];
      int idx;
      int roll;
      seq[0] = 2'b00; seq[1] = 2'b10; seq[2] = 2'b11; seq[3] = 2'b01;
      vif.tick = 1'b0;
      vif.beam_out = 1'b0;
      vif.beam_in = 1'b0;

      cycle(2'b00, 1'b0, 1'b1);
      cycle(2'b00, 1'b0, 1'b1);
      check_eq("reset_busy", int'(vif.busy), 0);
      check_eq("reset_fault", int'(vif.fault), 0);

      // Clean entry, each pattern held 3 cycles.
      clear_counts();
      hold(2'b10, 3); hold(2'b11, 3); hold(2'b01, 3); hold(2'b00, 3);
      check_eq("entry_count", n_entry_seen, 1);
      check_eq("entry_no_exit", n_exit_seen, 0);

      // Clean exit.
      clear_counts();
      hold(2'b01, 2); hold(2'b11, 2); hold(2'b10, 2); hold(2'b00, 2);
      check_eq("exit_count", n_exit_seen, 1);
      check_eq("exit_no_entry", n_entry_seen, 0);

      // Aborts and reversals.
      clear_counts();
      hold(2'b10, 2); hold(2'b00, 2);
      hold(2'b10, 1); hold(2'b11, 1); hold(2'b10, 1); hold(2'b00, 2);
      check_eq("abort_pulses", n_entry_seen + n_exit_seen, 0);
      hold(2'b10, 1); hold(2'b11, 1); hold(2'b01, 1); hold(2'b11, 1); hold(2'b01, 1);
      hold(2'b00, 2);
      check_eq("reversal_entry", n_entry_seen, 1);

      // Illegal pattern and fault recovery after four 00 samples.
      hold(2'b11, 1);
      check_eq("illegal_fault", int'(vif.fault), 1);
      hold(2'b00, 3);
      check_eq("fault_held", int'(vif.fault), 1);
      hold(2'b00, 1);
      check_eq("fault_cleared", int'(vif.fault), 0);

      // Timeout: hold 10 with a tick every 10 cycles; fault on the 5th tick.
      clear_counts();
      for (int i = 0; i < 50; i++) cycle(2'b10, (i % 10) == 9, 1'b0);
      check_eq("timeout_fault", int'(vif.fault), 1);
      hold(2'b00, 5);
      check_eq("timeout_no_pulse", n_entry_seen + n_exit_seen, 0);

      // Reset coincident with the final 00 of an entry suppresses the pulse.
      clear_counts();
      hold(2'b10, 1); hold(2'b11, 1); hold(2'b01, 1);
      cycle(2'b00, 1'b0, 1'b1);
      check_eq("reset_suppress", n_entry_seen, 0);
      hold(2'b00, 2);

      // Random walk along the lane sequence 00,10,11,01 with occasional jumps and ticks.
      clear_counts();
      idx = 0;
      for (int i = 0; i < 4000; i++) begin
         roll = $urandom_range(0, 99);
         if (roll < 15) idx = (idx + 1) % 4;
         else if (roll < 23) idx = (idx + 3) % 4;
         else if (roll < 25) idx = $urandom_range(0, 3);
         cycle(seq[idx], $urandom_range(0, 7) == 0, $urandom_range(0, 599) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/vehicle_direction_detector.md
# vehicle_direction_detector

Upstream stage of the parking controller's occupancy FSM. It watches a pair of debounced beam sensors mounted across the gate lane and decodes the order in which they break and clear. From that it emits a single-cycle `entry_pulse` or `exit_pulse` per complete vehicle passage. It also rejects aborted passages (vehicle backs out), illegal beam patterns and stuck sensors, so the FSM sees only clean, mutually exclusive events.

## Interface
- `TIMEOUT_TICKS`, default 2000: maximum number of `tick` pulses allowed inside one passage before declaring a fault; legal range 2..65535.
- `clk`  in  1  system clock (40 MHz domain, same as the occupancy FSM).
- `reset`  in  1  synchronous, active-high; sampled on rising `clk`.
- `tick`  in  1  one-cycle timebase enable (1 ms nominal) from the frequency divider.
- `beam_out`  in  1  outer (street-side) beam; 1 = beam broken; already debounced and in the `clk` domain.
- `beam_in`  in  1  inner (lot-side) beam; 1 = beam broken; already debounced and in the `clk` domain.
- `entry_pulse`  out  1  one-cycle pulse on a completed outside→inside passage.
- `exit_pulse`  out  1  one-cycle pulse on a completed inside→outside passage.
- `busy`  out  1  high while a passage is in progress (state not IDLE and not FAULT).
- `fault`  out  1  high while in FAULT.

## Operation
- States: IDLE, EN1 (out only), EN2 (both), EN3 (in only), EX1 (in only), EX2 (both), EX3 (out only), FAULT.
- Sensor pair sampled each cycle as {beam_out, beam_in}.
- Transitions from IDLE:
  - 10 → EN1.
  - 01 → EX1.
  - 11 → FAULT.
  - 00 → stay.
- Entry path:
  - EN1: 11 → EN2; 00 → IDLE with no pulse (abort); 01 → FAULT.
  - EN2: 01 → EN3; 10 → EN1 (reversing).
  - EN3: 00 → IDLE with `entry_pulse`; 11 → EN2.
  - Any pattern not listed for EN1–EN3 → FAULT.
- The exit path is the mirror image with beam roles swapped: EX1/EX2/EX3, ending with 00 in EX3 → IDLE with `exit_pulse`.
- FAULT: leave to IDLE only after 00 has been sampled on 4 consecutive cycles. No pulse is produced on this exit.
- Timeout counter:
  - Width: 16 bits.
  - Cleared on every state change and whenever the state is IDLE or FAULT.
  - Increments on `tick` in EN*/EX* states.
  - If `tick` arrives while the counter equals `TIMEOUT_TICKS-1`, the next state is FAULT. This takes priority over the beam-decoded transition in the same cycle.
- `entry_pulse` and `exit_pulse` are never high together and never high for two consecutive cycles.

## Timing
- All outputs are registered. Reset values: state IDLE, counter 0, `entry_pulse`=0, `exit_pulse`=0, `busy`=0, `fault`=0.
- Pulse latency: if 00 is sampled in EN3 at edge k, then `entry_pulse`=1 for exactly the cycle following edge k, and `busy` falls at the same edge.
- `busy` and `fault` reflect the state register. They change at the same edge as the state.
- Reset asserted mid-passage: the next edge forces IDLE and drops all outputs, with no pulse. A pulse that would have been emitted at that edge is suppressed.
- A minimum passage is 4 state changes, i.e. 4 cycles from the first break to the pulse. No minimum dwell per state.
- `tick` coincident with a state change: the counter clears and does not increment.

## Structure
- The shared parking package holds:
  - the state enum `vdd_state_t` (3 bits, IDLE=0);
  - the constant `FAULT_CLEAR_CYCLES`=4;
  - the sensor-pattern localparams `P_NONE`, `P_OUT`, `P_IN`, `P_BOTH`.
- One natural sub-module: `passage_timer`, the 16-bit tick counter with clear, enable and a terminal-count flag. It is reusable by the gate-door flasher.
- Placement: top-level instantiates this block between the Debouncers and the FSM, replacing the raw sensor inputs to the FSM.

## Test plan
- **Clean entry:** from IDLE apply 10, 11, 01, 00, each held for 3 cycles → exactly one `entry_pulse`, 1 cycle after the first 00 sample; `exit_pulse` stays 0; `busy` is high from the first 10 until the pulse.
- **Clean exit:** apply 01, 11, 10, 00 → exactly one `exit_pulse`; no `entry_pulse`.
- **Abort and reversal:**
  - 10, 00 → no pulse; returns to IDLE.
  - 10, 11, 10, 00 → no pulse.
  - 10, 11, 01, 11, 01, 00 → one `entry_pulse`.
- **Illegal pattern:**
  - 11 from IDLE → `fault`=1.
  - Then 00 held for 3 cycles → still FAULT.
  - Then a 4th cycle of 00 → IDLE on the next edge.
- **Timeout:** `TIMEOUT_TICKS`=5, hold 10 with `tick` every 10 cycles → FAULT at the 5th tick edge; no pulse.
- **Reset mid-passage:** reset asserted in the same cycle as the final 00 of an entry → no `entry_pulse`; all outputs 0 on the next cycle.
